cmp_minmax_ctrl: RTL and testbench

CMP_MINMAX_CTRL -- requirements
Module: cmp_minmax_ctrl

---
 rtl/cmp_minmax_ctrl.sv | 117 +++++++++++
 tb/tb_cmp_minmax_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cmp_minmax_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cmp_minmax_ctrl
// Brief   : Frame-based running min/max tracker. It counts the accepted
//           samples, saturating at 63, and flags frames whose samples are all
//           the same value. A three-state controller (IDLE/RUN/DONE) frames
//           the accumulation, and done pulses for one cycle when the results
//           are final.
// Revision: 1.0 - initial release
// ============================================================================
module cmp_minmax_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] min_out,
  output logic [5:0]       count,
  output logic             all_eq
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  localparam logic [5:0] COUNT_MAX = 6'd63;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [5:0]       count_q, count_d;
  logic             all_eq_q, all_eq_d;
  logic             accept;

  // State register; reset takes effect immediately, without a clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: DONE always lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (accept && in_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Controller outputs depend on the state alone, so in_ready never depends on in_valid
  always_comb begin
    in_ready = (state_q == S_RUN);
    busy     = (state_q == S_RUN) || (state_q == S_DONE);
    done     = (state_q == S_DONE);
  end

  assign accept = in_valid & in_ready;

  // Result update: initialise on frame open, then fold in each accepted sample
  always_comb begin
    max_d    = max_q;
    min_d    = min_q;
    count_d  = count_q;
    all_eq_d = all_eq_q;
    if ((state_q == S_IDLE) && start) begin
      max_d    = '0;
      min_d    = {WIDTH{1'b1}};
      count_d  = '0;
      all_eq_d = 1'b1;
    end else if (accept) begin
      if (count_q == 6'd0) begin
        // First sample seeds both extremes regardless of the init values
        max_d = in_data;
        min_d = in_data;
      end else begin
        if (in_data > max_q) max_d = in_data;
        if (in_data < min_q) min_d = in_data;
        // All samples so far equal max_q, so one mismatch against it is enough
        if (in_data != max_q) all_eq_d = 1'b0;
      end
      if (count_q != COUNT_MAX) count_d = count_q + 6'd1;
    end
  end

  // Result registers; their values are held from DONE through IDLE until the next start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q    <= '0;
      min_q    <= '0;
      count_q  <= '0;
      all_eq_q <= 1'b0;
    end else begin
      max_q    <= max_d;
      min_q    <= min_d;
      count_q  <= count_d;
      all_eq_q <= all_eq_d;
    end
  end

  assign max_out = max_q;
  assign min_out = min_q;
  assign count   = count_q;
  assign all_eq  = all_eq_q;

endmodule
`default_nettype wire

// File: tb/tb_cmp_minmax_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cmp_minmax_ctrl
// Brief   : Scoreboard bench for cmp_minmax_ctrl. Directed frames push their
//           hand-computed results into a queue. A monitor pops an entry and
//           compares it on every done pulse.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cmp_minmax_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [4:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [4:0] max_out;
  logic [4:0] min_out;
  logic [5:0] count;
  logic       all_eq;

  typedef struct packed {
    logic [4:0] mx;
    logic [4:0] mn;
    logic [5:0] cnt;
    logic       eq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;

  cmp_minmax_ctrl #(.WIDTH(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .max_out  (max_out),
    .min_out  (min_out),
    .count    (count),
    .all_eq   (all_eq)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: each done pulse must match the oldest expected frame result
  always @(negedge clk) begin
    if (done) begin
      chk("done_width", int'(prev_done), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("max_out", int'(max_out), int'(e.mx));
        chk("min_out", int'(min_out), int'(e.mn));
        chk("count",   int'(count),   int'(e.cnt));
        chk("all_eq",  int'(all_eq),  int'(e.eq));
      end
    end
    prev_done = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open_frame(input exp_t e);
    exp_q.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [4:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (l) chk("done_latency", int'(done), 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    #1;
    // Reset values appear before any clock edge
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy",     int'(busy),     0);
    chk("rst_max",      int'(max_out),  0);
    chk("rst_min",      int'(min_out),  0);
    chk("rst_count",    int'(count),    0);
    chk("rst_all_eq",   int'(all_eq),   0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Mixed values, back to back
    open_frame('{mx: 5'd19, mn: 5'd3, cnt: 6'd4, eq: 1'b0});
    chk("run_in_ready", int'(in_ready), 1);
    send(5'd7, 1'b0); send(5'd3, 1'b0); send(5'd19, 1'b0); send(5'd3, 1'b1);
    tick(); tick();

    // Single-sample frame
    open_frame('{mx: 5'd12, mn: 5'd12, cnt: 6'd1, eq: 1'b1});
    send(5'd12, 1'b1);
    tick(); tick();

    // Equal samples with idle gaps carrying a stray in_last
    open_frame('{mx: 5'd9, mn: 5'd9, cnt: 6'd3, eq: 1'b1});
    send(5'd9, 1'b0);
    in_data = 5'd0; in_last = 1'b1;
    tick(); tick();
    in_last = 1'b0;
    chk("gap_count", int'(count), 1);
    chk("gap_busy",  int'(busy),  1);
    send(5'd9, 1'b0);
    tick();
    send(5'd9, 1'b1);
    tick(); tick();

    // Extremes, then start pulse in DONE and valid data in IDLE
    open_frame('{mx: 5'd31, mn: 5'd0, cnt: 6'd2, eq: 1'b0});
    send(5'd0, 1'b0); send(5'd31, 1'b1);
    start = 1'b1; in_valid = 1'b1; in_data = 5'd7; in_last = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("hold_busy",     int'(busy),     0);
    chk("hold_in_ready", int'(in_ready), 0);
    chk("hold_max",      int'(max_out),  31);
    chk("hold_min",      int'(min_out),  0);
    chk("hold_count",    int'(count),    2);
    chk("hold_all_eq",   int'(all_eq),   0);
    in_valid = 1'b0; in_last = 1'b0;
    tick();

    // Count saturation
    open_frame('{mx: 5'd5, mn: 5'd5, cnt: 6'd63, eq: 1'b1});
    for (int i = 1; i <= 70; i++) send(5'd5, (i == 70));
    tick(); tick();

    // Asynchronous reset in the middle of a frame
    start = 1'b1;
    tick();
    start = 1'b0;
    send(5'd4, 1'b0); send(5'd20, 1'b0);
    chk("pre_rst_count", int'(count), 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",   int'(busy),    0);
    chk("arst_ready",  int'(in_ready), 0);
    chk("arst_max",    int'(max_out), 0);
    chk("arst_min",    int'(min_out), 0);
    chk("arst_count",  int'(count),   0);
    in_valid = 1'b1; in_data = 5'd3;
    @(negedge clk);
    #2 rst = 1'b0;
    tick();
    chk("rel_count", int'(count),    0);
    chk("rel_ready", int'(in_ready), 0);
    in_valid = 1'b0;
    open_frame('{mx: 5'd8, mn: 5'd8, cnt: 6'd1, eq: 1'b1});
    send(5'd8, 1'b1);

    // Bounded wait for every expected frame to be reported
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) chk("frames_pending", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
